// File: rtl/cdc_handshake_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx_if
//  Description : Bus bundle for the transmit end of a toggle req/ack CDC.
//                Carries the local send handshake (send_valid/send_data/
//                send_ready/send_done/busy) and the crossing signals
//                (req_toggle/xfer_data out, ack_toggle in).
//                With CDC_TX_TIMEOUT_EN defined it also carries the sticky
//                timeout_err flag and its err_clr clear input.
//  Modports    : slave  - the transmitter (cdc_handshake_tx)
//                master - the user/environment driving it
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdc_handshake_tx_if #(
    parameter int DATA_W = 8
);
    logic              send_valid;
    logic [DATA_W-1:0] send_data;
    logic              send_ready;
    logic              send_done;
    logic              busy;
    logic              req_toggle;
    logic [DATA_W-1:0] xfer_data;
    logic              ack_toggle;
`ifdef CDC_TX_TIMEOUT_EN
    logic              timeout_err;
    logic              err_clr;
`endif

    modport slave (
        input  send_valid,
        input  send_data,
        output send_ready,
        output send_done,
        output busy,
        output req_toggle,
        output xfer_data,
`ifdef CDC_TX_TIMEOUT_EN
        output timeout_err,
        input  err_clr,
`endif
        input  ack_toggle
    );

    modport master (
        output send_valid,
        output send_data,
        input  send_ready,
        input  send_done,
        input  busy,
        input  req_toggle,
        input  xfer_data,
`ifdef CDC_TX_TIMEOUT_EN
        input  timeout_err,
        output err_clr,
`endif
        output ack_toggle
    );
endinterface
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source-side end of a toggle req/ack clock-domain crossing.
//                A word accepted in the outclk domain is registered onto
//                xfer_data and announced by flipping req_toggle. The block
//                then waits until the synchronized ack_toggle matches
//                req_toggle, pulses send_done and becomes ready again.
//  Ports       : outclk - source clock (all state on posedge)
//                reset  - asynchronous, active-high
//                bus    - cdc_handshake_tx_if.slave (send handshake,
//                         req_toggle/xfer_data, ack_toggle, optional
//                         timeout_err/err_clr)
//  Parameters  : DATA_W         - transferred word width
//                SYNC_STAGES    - ack synchronizer depth (>= 2)
//                TIMEOUT_CYCLES - ack wait limit (CDC_TX_TIMEOUT_EN only)
//  Options     : CDC_TX_TIMEOUT_EN - adds the WAIT_ACK cycle counter and the
//                sticky timeout_err flag with its err_clr clear
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int DATA_W         = 8,
`ifdef CDC_TX_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    parameter int SYNC_STAGES    = 2
) (
    input wire                  outclk,
    input wire                  reset,
    cdc_handshake_tx_if.slave   bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_WAIT_ACK = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;

    logic                   r_ready;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_req;
    logic [DATA_W-1:0]      r_xfer_data;
    logic [SYNC_STAGES-1:0] r_ack_sync;

    logic                   w_ack_sync;
    logic                   w_accept;
    logic                   w_ack_match;
    logic                   w_ready_nxt;
    logic                   w_done_nxt;
    logic                   w_busy_nxt;

    // ------------------------------------------------------------------
    // ack_toggle synchronizer. Bit 0 is the only flop that sees the raw
    // asynchronous level; everything downstream uses the last stage.
    // ------------------------------------------------------------------
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_toggle};
        end
    end

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept requires the registered ready, so the first cycle after reset
    // (ready still low) can never accept a word.
    assign w_accept    = (r_state == S_IDLE) && bus.send_valid && r_ready;
    // req_toggle already holds the new level in the first WAIT_ACK cycle, so
    // a match means the destination has echoed the current request.
    assign w_ack_match = (w_ack_sync == r_req);

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (w_ack_match) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered status outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt = !w_accept;
                w_busy_nxt  = w_accept;
            end
            S_WAIT_ACK: begin
                w_ready_nxt = w_ack_match;
                w_done_nxt  = w_ack_match;
                w_busy_nxt  = !w_ack_match;
            end
            default: begin
                w_ready_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and crossing datapath
    // ------------------------------------------------------------------
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_req       <= 1'b0;
            r_xfer_data <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            // xfer_data and req_toggle move only on an accept edge, which
            // keeps the word stable for the destination while busy.
            if (w_accept) begin
                r_xfer_data <= bus.send_data;
                r_req       <= ~r_req;
            end
        end
    end

    assign bus.send_ready = r_ready;
    assign bus.send_done  = r_done;
    assign bus.busy       = r_busy;
    assign bus.req_toggle = r_req;
    assign bus.xfer_data  = r_xfer_data;

`ifdef CDC_TX_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Ack wait timeout. The counter saturates at TIMEOUT_CYCLES so a long
    // wait cannot wrap; the flag is only reported, the FSM keeps waiting.
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;
    logic             w_tmo_hit;

    // Hit on the WAIT_ACK edge that takes the count to TIMEOUT_CYCLES.
    assign w_tmo_hit = (r_state == S_WAIT_ACK) && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_WAIT_ACK) && (r_tmo_cnt != c_TMO_MAX)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_handshake_tx
//  Description : Directed bench for cdc_handshake_tx. Accepted words are
//                pushed to a scoreboard queue and popped on send_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    localparam int DATA_W = 8;

    logic clk;
    logic rst;

    int   n_vec;
    int   n_err;
    int   done_cnt;
    int   lat;
    logic exp_req;
    logic [DATA_W-1:0] sb_q[$];

    cdc_handshake_tx_if #(.DATA_W(DATA_W)) bus ();

    cdc_handshake_tx #(
        .DATA_W         (DATA_W),
`ifdef CDC_TX_TIMEOUT_EN
        .TIMEOUT_CYCLES (16),
`endif
        .SYNC_STAGES    (2)
    ) u_dut (
        .outclk (clk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs move and checks run 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        bus.send_valid = 1'b1;
        bus.send_data  = d;
        tick();
        bus.send_valid = 1'b0;
        sb_q.push_back(d);
        exp_req = ~exp_req;
        chk("acc_xfer_data", 32'(bus.xfer_data), 32'(d));
        chk("acc_req",       32'(bus.req_toggle), 32'(exp_req));
        chk("acc_busy",      32'(bus.busy), 32'd1);
        chk("acc_ready",     32'(bus.send_ready), 32'd0);
    endtask

    // Returns edges counted until send_done rises, or -1 on expiry.
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.send_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Scoreboard consumer, sampled between the stimulus point and the next edge.
    always begin
        @(posedge clk);
        #2;
        if (bus.send_done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) chk("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
            else                  chk("sb_xfer_data", 32'(bus.xfer_data), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        n_vec = 0; n_err = 0; done_cnt = 0; exp_req = 1'b0;
        rst = 1'b1;
        bus.send_valid = 1'b0;
        bus.send_data  = '0;
        bus.ack_toggle = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        bus.err_clr    = 1'b0;
`endif

        // T1: reset state, ready rises on first edge after release
        repeat (3) tick();
        chk("t1_rst_ready", 32'(bus.send_ready), 32'd0);
        chk("t1_rst_busy",  32'(bus.busy), 32'd0);
        chk("t1_rst_done",  32'(bus.send_done), 32'd0);
        chk("t1_rst_req",   32'(bus.req_toggle), 32'd0);
        chk("t1_rst_xfer",  32'(bus.xfer_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("t1_ready_pre_edge", 32'(bus.send_ready), 32'd0);
        tick();
        chk("t1_ready_1st_edge", 32'(bus.send_ready), 32'd1);
        chk("t1_req",            32'(bus.req_toggle), 32'd0);

        // T2: single word, ack 5 cycles later, done 3 edges after ack
        send(8'hA5);
        repeat (4) tick();
        chk("t2_busy_wait", 32'(bus.busy), 32'd1);
        bus.ack_toggle = 1'b1;
        wait_done(10, lat);
        chk("t2_done_lat", 32'(lat), 32'd3);
        chk("t2_busy_off", 32'(bus.busy), 32'd0);
        chk("t2_ready_on", 32'(bus.send_ready), 32'd1);
        tick();
        chk("t2_done_pulse", 32'(bus.send_done), 32'd0);

        // T3: valid held across the ack, second word taken in done cycle
        bus.send_valid = 1'b1;
        bus.send_data  = 8'h01;
        tick();
        sb_q.push_back(8'h01);
        exp_req = ~exp_req;
        chk("t3_xfer_01", 32'(bus.xfer_data), 32'h01);
        chk("t3_req_0",   32'(bus.req_toggle), 32'(exp_req));
        bus.send_data = 8'h02;
        repeat (3) tick();
        chk("t3_xfer_hold", 32'(bus.xfer_data), 32'h01);
        bus.ack_toggle = 1'b0;
        wait_done(10, lat);
        chk("t3_done_lat", 32'(lat), 32'd3);
        tick();
        sb_q.push_back(8'h02);
        exp_req = ~exp_req;
        bus.send_valid = 1'b0;
        chk("t3_xfer_02", 32'(bus.xfer_data), 32'h02);
        chk("t3_req_1",   32'(bus.req_toggle), 32'(exp_req));
        chk("t3_busy_b2b", 32'(bus.busy), 32'd1);
        bus.ack_toggle = 1'b1;
        wait_done(10, lat);
        chk("t3_done2_lat", 32'(lat), 32'd3);
        tick();

        // T4: ack toggling while idle is ignored
        lat = done_cnt;
        bus.ack_toggle = 1'b0;
        repeat (2) tick();
        bus.ack_toggle = 1'b1;
        repeat (2) tick();
        bus.ack_toggle = 1'b0;
        repeat (2) tick();
        bus.ack_toggle = 1'b1;
        repeat (6) tick();
        chk("t4_no_done",  32'(done_cnt), 32'(lat));
        chk("t4_ready",    32'(bus.send_ready), 32'd1);
        chk("t4_busy",     32'(bus.busy), 32'd0);
        chk("t4_req",      32'(bus.req_toggle), 32'(exp_req));

        // T5: asynchronous reset two cycles after accept
        send(8'h3C);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("t5_ready", 32'(bus.send_ready), 32'd0);
        chk("t5_busy",  32'(bus.busy), 32'd0);
        chk("t5_done",  32'(bus.send_done), 32'd0);
        chk("t5_req",   32'(bus.req_toggle), 32'd0);
        chk("t5_xfer",  32'(bus.xfer_data), 32'd0);
        sb_q.delete();
        exp_req = 1'b0;
        bus.ack_toggle = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("t5_ready_after", 32'(bus.send_ready), 32'd1);

`ifdef CDC_TX_TIMEOUT_EN
        // T6: timeout after 16 WAIT_ACK cycles, late ack, clear
        send(8'h77);
        repeat (15) tick();
        chk("t6_err_before", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("t6_err_set",    32'(bus.timeout_err), 32'd1);
        chk("t6_still_busy", 32'(bus.busy), 32'd1);
        bus.ack_toggle = 1'b1;
        wait_done(10, lat);
        chk("t6_late_done", 32'(lat), 32'd3);
        chk("t6_err_sticky", 32'(bus.timeout_err), 32'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t6_err_clr", 32'(bus.timeout_err), 32'd0);
`endif

        repeat (3) tick();
        chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
